// File: rtl/mem_sync_bytes.sv
// Byte-addressable data memory with pipelined read, write-first forwarding and range flags.
// Optional MEM_ALIGN_CHK_EN: misaligned addresses are rejected like out-of-range ones.
module mem_sync_bytes #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int RD_LAT      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   adrs_rd,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_err,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] byt_en,
  input  logic [ADDR_W-1:0]   adrs_wr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_err
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  function automatic logic bad_adr(input logic [ADDR_W-1:0] a);
    logic b;
    b = (a >> AW) != '0;
`ifdef MEM_ALIGN_CHK_EN
    b = b | ((a & ADDR_W'(NB - 1)) != '0);
`endif
    return b;
  endfunction

  logic          rd_bad;
  logic          wr_bad;
  logic          wr_ok;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] wr_base;

  assign rd_bad  = bad_adr(adrs_rd);
  assign wr_bad  = bad_adr(adrs_wr);
  assign wr_ok   = wr_en && !wr_bad;
  assign rd_base = adrs_rd[AW-1:0];
  assign wr_base = adrs_wr[AW-1:0];

  // Read capture; bytes being written this cycle win over stored ones.
  logic [DATA_W-1:0] cap;
  logic [AW-1:0]     ra;
  logic [7:0]        bv;

  always_comb begin
    cap = '0;
    ra  = '0;
    bv  = '0;
    if (!rd_bad) begin
      for (int k = 0; k < NB; k++) begin
        ra = rd_base + AW'(k);
        bv = mem[ra];
        if (wr_ok) begin
          for (int j = 0; j < NB; j++) begin
            if (byt_en[j] && (wr_base + AW'(j)) == ra)
              bv = wr_data[8*j +: 8];
          end
        end
        cap[8*k +: 8] = bv;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (byt_en[k])
          mem[wr_base + AW'(k)] <= wr_data[8*k +: 8];
      end
    end
  end

  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pe;
  logic [DATA_W-1:0] pd [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < RD_LAT; i++)
        pd[i] <= '0;
    end else begin
      pv[0] <= rd_en;
      if (rd_en) begin
        pd[0] <= cap;
        pe[0] <= rd_bad;
      end
      // Stages only load on valid so the output holds between reads.
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
          pe[i] <= pe[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_err <= 1'b0;
    else
      wr_err <= wr_en && (byt_en != '0) && wr_bad;
  end

  assign rd_valid = pv[RD_LAT-1];
  assign rd_data  = pd[RD_LAT-1];
  assign rd_err   = pe[RD_LAT-1];

endmodule

// File: tb/tb_mem_sync_bytes.sv
// Directed bench for mem_sync_bytes: RD_LAT=1 instance plus an RD_LAT=3 instance.
module tb_mem_sync_bytes;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst3;
  logic        rd_en;
  logic        rd_en3;
  logic [31:0] adrs_rd;
  logic [31:0] adrs_rd3;
  logic        wr_en;
  logic [3:0]  byt_en;
  logic [31:0] adrs_wr;
  logic [31:0] wr_data;

  logic        rd_valid, rd_err, wr_err;
  logic [31:0] rd_data;
  logic        rd_valid3, rd_err3, wr_err3;
  logic [31:0] rd_data3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_sync_bytes dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .adrs_rd(adrs_rd),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .wr_en(wr_en), .byt_en(byt_en), .adrs_wr(adrs_wr),
    .wr_data(wr_data), .wr_err(wr_err)
  );

  mem_sync_bytes #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst3),
    .rd_en(rd_en3), .adrs_rd(adrs_rd3),
    .rd_valid(rd_valid3), .rd_data(rd_data3), .rd_err(rd_err3),
    .wr_en(wr_en), .byt_en(byt_en), .adrs_wr(adrs_wr),
    .wr_data(wr_data), .wr_err(wr_err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    wr_en   = 1'b1;
    adrs_wr = a;
    wr_data = d;
    byt_en  = be;
  endtask

  task automatic rd(input logic [31:0] a);
    rd_en   = 1'b1;
    adrs_rd = a;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    byt_en = 4'h0;
  endtask

  initial begin
    rst = 0; rst3 = 0;
    rd_en = 0; rd_en3 = 0; wr_en = 0;
    adrs_rd = 0; adrs_rd3 = 0; adrs_wr = 0;
    wr_data = 0; byt_en = 0;
    #2;
    rst = 1; rst3 = 1;
    tick(); tick();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_err", 32'(rd_err), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_rd_valid3", 32'(rd_valid3), 32'd0);
    rst = 0; rst3 = 0;
    tick();

    // T1
    wr(32'h10, 32'hDEADBEEF, 4'hF); tick();
    idle(); rd(32'h10);
    check("t1_pre_valid", 32'(rd_valid), 32'd0);
    tick();
    check("t1_valid", 32'(rd_valid), 32'd1);
    check("t1_data", rd_data, 32'hDEADBEEF);
    check("t1_err", 32'(rd_err), 32'd0);
    idle(); tick();
    check("t1_hold_valid", 32'(rd_valid), 32'd0);
    check("t1_hold_data", rd_data, 32'hDEADBEEF);

    // T2
    wr(32'h20, 32'h11223344, 4'hF); tick();
    wr(32'h20, 32'hAABBCCDD, 4'b0101); tick();
    idle(); rd(32'h20); tick();
    check("t2_data", rd_data, 32'h11BB33DD);
    rd(32'h10); tick();
    check("b2b_valid", 32'(rd_valid), 32'd1);
    check("b2b_data", rd_data, 32'hDEADBEEF);
    idle();

`ifdef MEM_ALIGN_CHK_EN
    rd(32'h11); tick();
    check("al_err", 32'(rd_err), 32'd1);
    check("al_data", rd_data, 32'd0);
    idle();
`else
    // T3
    wr(32'h44, 32'h55667788, 4'hF); tick();
    wr(32'h40, 32'hCAFEF00D, 4'hF); rd(32'h42); tick();
    check("t3_fwd", rd_data, 32'h7788CAFE);
    idle(); rd(32'h40); tick();
    check("t3_stored", rd_data, 32'hCAFEF00D);
    idle();

    // T4
    wr(32'h3FE, 32'h01020304, 4'hF); tick();
    idle(); rd(32'h3FE); tick();
    check("t4_wrap", rd_data, 32'h01020304);
    check("t4_err", 32'(rd_err), 32'd0);
    rd(32'h0); tick();
    check("t4_low", {16'h0, rd_data[15:0]}, 32'h00000102);
    idle();
`endif

    // T5
    wr(32'h0, 32'h99887766, 4'hF); tick();
    wr(32'h400, 32'hFFFFFFFF, 4'hF); tick();
    check("t5_wr_err", 32'(wr_err), 32'd1);
    idle(); rd(32'h400); tick();
    check("t5_rd_err", 32'(rd_err), 32'd1);
    check("t5_rd_zero", rd_data, 32'd0);
    check("t5_wr_err_clr", 32'(wr_err), 32'd0);
    rd(32'h0); tick();
    check("t5_mem0", rd_data, 32'h99887766);
    check("t5_err_clr", 32'(rd_err), 32'd0);
    idle(); wr(32'h400, 32'h0, 4'h0); tick();
    check("t5_be0_wr_err", 32'(wr_err), 32'd0);
    idle();
`ifndef MEM_ALIGN_CHK_EN
    wr(32'h3FC, 32'h03AABBCC, 4'hF); tick();
    idle(); rd(32'h3FF); tick();
    check("wrap_3ff", rd_data, 32'h88776603);
    idle();
`endif

    // T6 on the RD_LAT=3 instance
    wr(32'h0, 32'h10203040, 4'hF); tick();
    wr(32'h4, 32'h13572468, 4'hF); tick();
    wr(32'h8, 32'h0BADCAFE, 4'hF); tick();
    idle();
    rd_en3 = 1; adrs_rd3 = 32'h0; tick();
    check("t6_c1_valid", 32'(rd_valid3), 32'd0);
    adrs_rd3 = 32'h4; tick();
    check("t6_c2_valid", 32'(rd_valid3), 32'd0);
    adrs_rd3 = 32'h8; tick();
    check("t6_c3_valid", 32'(rd_valid3), 32'd1);
    check("t6_c3_data", rd_data3, 32'h10203040);
    rd_en3 = 0; tick();
    check("t6_c4_valid", 32'(rd_valid3), 32'd1);
    check("t6_c4_data", rd_data3, 32'h13572468);
    tick();
    check("t6_c5_valid", 32'(rd_valid3), 32'd1);
    check("t6_c5_data", rd_data3, 32'h0BADCAFE);
    tick();
    check("t6_c6_valid", 32'(rd_valid3), 32'd0);
    check("t6_c6_hold", rd_data3, 32'h0BADCAFE);

    wr(32'hC, 32'hA5A5A5A5, 4'hF); tick();
    idle();
    rd_en3 = 1; adrs_rd3 = 32'h0; tick();
    adrs_rd3 = 32'h4; tick();
    rst3 = 1; #1;
    check("t6_rst_valid", 32'(rd_valid3), 32'd0);
    check("t6_rst_data", rd_data3, 32'd0);
    check("t6_rst_err", 32'(rd_err3), 32'd0);
    rd_en3 = 0;
    wr(32'hC, 32'h5A5A5A5A, 4'hF); tick();
    idle(); tick();
    rst3 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_post_rst_valid%0d", i), 32'(rd_valid3), 32'd0);
    end
    rd_en3 = 1; adrs_rd3 = 32'hC; tick();
    rd_en3 = 0; tick(); tick();
    check("t6_rstwr_valid", 32'(rd_valid3), 32'd1);
    check("t6_rstwr_data", rd_data3, 32'hA5A5A5A5);
    rd(32'hC); tick();
    check("t6_shared_wr", rd_data, 32'h5A5A5A5A);
    idle(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
